// File: rtl/o_serializer.sv
// o_serializer: parallel-to-serial shifter with valid/ready acceptance, clock enable and back-to-back streaming
// Ports:
//   C      posedge clock
//   R      asynchronous active-low reset
//   E      active-high clock enable; low freezes all state
//   D      parallel word, captured when VALID & READY at a posedge
//   VALID  D holds a word to send
//   READY  combinational: E & (idle | last bit on Q)
//   Q      registered serial data, IDLE_VALUE when no word is in flight
//   ACTIVE registered; Q carries a word bit
//   LAST   registered; Q carries the final bit of a word
module o_serializer #(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_VALUE = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  input  logic             VALID,
  output logic             READY,
  output logic             Q,
  output logic             ACTIVE,
  output logic             LAST
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  // Declaration values give the reset state at power-up without R being pulsed.
  state_t           state    = IDLE;
  logic [CW-1:0]    cnt      = '0;
  logic [WIDTH-1:0] sr       = '0;
  logic             q_r      = IDLE_VALUE;
  logic             active_r = 1'b0;
  logic             last_r   = 1'b0;
  assign READY  = E & ((state == IDLE) | last_r);
  assign Q      = q_r;
  assign ACTIVE = active_r;
  assign LAST   = last_r;
  // sr holds the bits not yet on Q, already aligned so the next bit sits at the send end.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      state    <= IDLE;
      cnt      <= '0;
      sr       <= '0;
      q_r      <= IDLE_VALUE;
      active_r <= 1'b0;
      last_r   <= 1'b0;
    end else if (E) begin
      if (READY && VALID) begin
        state    <= SHIFT;
        cnt      <= '0;
        q_r      <= MSB_FIRST ? D[WIDTH-1] : D[0];
        sr       <= MSB_FIRST ? D << 1 : D >> 1;
        active_r <= 1'b1;
        last_r   <= 1'b0;
      end else if (state == IDLE || last_r) begin
        state    <= IDLE;
        cnt      <= '0;
        q_r      <= IDLE_VALUE;
        active_r <= 1'b0;
        last_r   <= 1'b0;
      end else begin
        cnt    <= cnt + 1'b1;
        q_r    <= MSB_FIRST ? sr[WIDTH-1] : sr[0];
        sr     <= MSB_FIRST ? sr << 1 : sr >> 1;
        last_r <= (cnt == CW'(WIDTH - 2));
      end
    end
  end
endmodule

// File: doc/o_serializer.md
O_SERIALIZER -- requirements
Module: o_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width; legal range 3..10.
REQ-002 SHALL have parameter MSB_FIRST, default 1'b1; 1 = D[WIDTH-1] sent first, 0 = D[0] sent first.
REQ-003 SHALL have parameter IDLE_VALUE, default 1'b0, value driven on Q when no word is in flight.
REQ-004 SHALL have port C  input  1  posedge clock; the only clock.
REQ-005 SHALL have port R  input  1  reset; asynchronous and active-low.
REQ-006 SHALL have port E  input  1  active-high clock enable; E=0 freezes all state.
REQ-007 SHALL have port D  input  WIDTH  parallel word to serialize.
REQ-008 SHALL have port VALID  input  1  D holds a word to send.
REQ-009 SHALL have port READY  output  1  word is accepted at the next posedge C when VALID=1.
REQ-010 SHALL have port Q  output  1  registered serial data.
REQ-011 SHALL have port ACTIVE  output  1  registered; Q carries a word bit.
REQ-012 SHALL have port LAST  output  1  registered; Q carries the final bit of a word.

Function
REQ-013 SHALL implement two states: IDLE (no word in flight) and SHIFT (word in flight).
REQ-014 SHALL accept a word on posedge C when E=1, VALID=1 and READY=1.
REQ-015 SHALL drive READY combinationally as E & (state==IDLE | LAST); READY SHALL not depend on VALID.
REQ-016 SHALL present the first bit of an accepted word on Q in the cycle after the accepting edge (latency 1).
REQ-017 SHALL advance one bit per posedge C with E=1; a WIDTH-bit word SHALL occupy exactly WIDTH enabled cycles on Q.
REQ-018 SHALL use a bit counter of ceil(log2(WIDTH)) bits, 0 at the first bit, WIDTH-1 at the last bit, with no wrap beyond WIDTH-1.
REQ-019 SHALL assert LAST exactly when the counter equals WIDTH-1 in SHIFT.
REQ-020 SHALL load the next word at the edge ending the last bit when VALID=1 there, with no gap cycle (back-to-back streaming).
REQ-021 SHALL return to IDLE at the edge ending the last bit when VALID=0 there (underrun); Q=IDLE_VALUE, ACTIVE=0, LAST=0 from that edge.
REQ-022 SHALL keep state, counter, Q, ACTIVE and LAST unchanged on any posedge C with E=0; no word is accepted while E=0.
REQ-023 SHALL ignore D and VALID while in SHIFT with LAST=0.
REQ-024 SHALL capture D into an internal shift register at acceptance; later changes of D SHALL not affect the word in flight.
REQ-025 SHALL drive Q, ACTIVE and LAST from flops only, with no combinational path from inputs.

Reset
REQ-026 SHALL, while R=0, force state=IDLE, counter=0, Q=IDLE_VALUE, ACTIVE=0, LAST=0 immediately, independent of C and E.
REQ-027 SHALL discard any word in flight when R falls mid-word; no partial bits SHALL appear after R returns high.
REQ-028 SHALL give R=0 priority over a simultaneous posedge C and VALID.
REQ-029 SHALL act on R rising at the first posedge C after release; READY SHALL equal E after release.
REQ-030 SHALL power up in the reset state when simulated without asserting R.

Verification
REQ-031 SHALL cover single word: WIDTH=8, MSB_FIRST=1, D=8'hA5, one VALID pulse, E=1 -> Q=1,0,1,0,0,1,0,1 over cycles 1..8; ACTIVE=1 for those 8; LAST only in cycle 8; then Q=0.
REQ-032 SHALL cover back-to-back: VALID held with 8'hF0 then 8'h0F -> 16 contiguous ACTIVE cycles with Q=11110000 00001111; READY high only in LAST cycles after the first acceptance.
REQ-033 SHALL cover enable stall: E=0 for 3 cycles after bit 3 of 8'hA5 -> Q holds bit 3 value 0 for 4 cycles, READY=0, then resumes; total 11 ACTIVE cycles.
REQ-034 SHALL cover reset mid-word: R=0 after bit 4 of 8'hFF -> Q=0, ACTIVE=0 immediately; after release with VALID=0 -> Q stays 0.
REQ-035 SHALL cover LSB-first with WIDTH=3, MSB_FIRST=0, IDLE_VALUE=1, D=3'b110 -> Q=0,1,1 with LAST on the 3rd bit; Q=1 when idle.
REQ-036 SHALL cover underrun: VALID=0 at LAST -> ACTIVE falls the next cycle; a new VALID=1 in IDLE is accepted at the next edge with first bit one cycle later.
